// File: rtl/ppu_pkg.sv
// Shared types, constants and the backdrop-mirror helper for the palette RAM.
package ppu_pkg;

    localparam int unsigned PAL_AW_MAX = 16;
    localparam int unsigned PAL_CPU_DW = 8;
    localparam logic [7:0]  PAL_GREY_MASK = 8'h30;

    typedef enum logic {
        PAL_CLEAR = 1'b0,
        PAL_RUN   = 1'b1
    } pal_state_t;

    // One buffered CPU request; addr is carried at maximum width.
    typedef struct packed {
        logic                  wr;
        logic [PAL_AW_MAX-1:0] addr;
        logic [PAL_CPU_DW-1:0] data;
    } pal_req_t;

    // Entries x0/x4/x8/xC of the sprite half alias the background half.
    function automatic logic [PAL_AW_MAX-1:0] pal_mirror(
        input logic [PAL_AW_MAX-1:0] addr,
        input logic                  mirror_bg
    );
        logic [PAL_AW_MAX-1:0] m;
        m = addr;
        if (mirror_bg) m[4] = addr[4] & (|addr[1:0]);
        return m;
    endfunction

endpackage

// File: rtl/pal_req_buf.sv
// Single-entry CPU request holding register; requests arriving while full are dropped.
module pal_req_buf
    import ppu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rd,
    input  logic                  i_wr,
    input  logic [PAL_AW_MAX-1:0] i_addr,
    input  logic [PAL_CPU_DW-1:0] i_data,
    input  logic                  i_pop,
    output logic                  o_full,
    output pal_req_t              o_req
);

    logic     r_full;
    pal_req_t r_req;

    // Latch a request into an empty slot (write wins over read); release on pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_req  <= '0;
        end else if (r_full) begin
            if (i_pop) r_full <= 1'b0;
        end else if (i_rd || i_wr) begin
            r_full <= 1'b1;
            r_req  <= '{wr: i_wr, addr: i_addr, data: i_data};
        end
    end

    assign o_full = r_full;
    assign o_req  = r_req;

endmodule

// File: rtl/palette_ram_arb.sv
// PPU palette RAM: render-priority arbitration, CPU request buffer, reset clear, greyscale.
module palette_ram_arb
    import ppu_pkg::*;
#(
    parameter int unsigned    ENTRIES        = 32,
    parameter int unsigned    AW             = $clog2(ENTRIES),
    parameter int unsigned    DW             = 6,
    parameter bit             MIRROR_BG      = 1'b1,
    parameter bit             CLEAR_ON_RESET = 1'b1,
    parameter logic [DW-1:0]  GREY_MASK      = DW'(PAL_GREY_MASK)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          busy,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [7:0]    cpu_data_i,
    output logic [7:0]    cpu_data_o,
    output logic          cpu_ack,
    input  logic          rend_en,
    input  logic [AW-1:0] rend_addr,
    input  logic          greyscale,
    output logic [DW-1:0] rend_data_o,
    output logic          rend_valid
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(ENTRIES - 1);

    pal_state_t    r_state, w_next;
    logic [AW-1:0] r_clr_cnt;
    logic          r_busy;
    logic          r_cpu_ack;
    logic [7:0]    r_cpu_data;
    logic          r_rend_valid;
    logic [DW-1:0] r_rend_data;
    logic [DW-1:0] r_mem [ENTRIES];

    logic          w_full;
    pal_req_t      w_req;
    logic [AW-1:0] w_cpu_map, w_rend_map, w_addr;
    logic          w_we, w_rend_go, w_cpu_go;
    logic [DW-1:0] w_wdata, w_rdata, w_mask;

    pal_req_buf u_req_buf (
        .clk    (clk),
        .rst    (rst),
        .i_rd   (cpu_rd),
        .i_wr   (cpu_wr),
        .i_addr (PAL_AW_MAX'(cpu_addr)),
        .i_data (cpu_data_i),
        .i_pop  (w_cpu_go),
        .o_full (w_full),
        .o_req  (w_req)
    );

    assign w_rend_map = AW'(pal_mirror(PAL_AW_MAX'(rend_addr), MIRROR_BG));
    assign w_cpu_map  = AW'(pal_mirror(w_req.addr, MIRROR_BG));
    assign w_rdata    = r_mem[w_addr];
    assign w_mask     = greyscale ? GREY_MASK : '1;

    // Next state and single-port ownership: clear, then render, then buffered CPU op.
    always_comb begin
        w_next    = r_state;
        w_we      = 1'b0;
        w_addr    = w_rend_map;
        w_wdata   = '0;
        w_rend_go = 1'b0;
        w_cpu_go  = 1'b0;
        case (r_state)
            PAL_CLEAR: begin
                w_we   = 1'b1;
                w_addr = r_clr_cnt;
                if (r_clr_cnt == LAST_ADDR) w_next = PAL_RUN;
            end
            PAL_RUN: begin
                if (rend_en) begin
                    w_rend_go = 1'b1;
                end else if (w_full) begin
                    w_cpu_go = 1'b1;
                    w_addr   = w_cpu_map;
                    w_we     = w_req.wr;
                    w_wdata  = DW'(w_req.data);
                end
            end
            default: w_next = PAL_RUN;
        endcase
    end

    // State register, clear counter and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR_ON_RESET ? PAL_CLEAR : PAL_RUN;
            r_clr_cnt <= '0;
            r_busy    <= CLEAR_ON_RESET;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == PAL_CLEAR);
            if (r_state == PAL_CLEAR) r_clr_cnt <= r_clr_cnt + AW'(1);
        end
    end

    // Palette array write port, kept reset-free for RAM inference.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_addr] <= w_wdata;
    end

    // Registered render and CPU responses; reads see the pre-write contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rend_valid <= 1'b0;
            r_rend_data  <= '0;
            r_cpu_ack    <= 1'b0;
            r_cpu_data   <= '0;
        end else begin
            r_rend_valid <= w_rend_go;
            r_cpu_ack    <= w_cpu_go;
            if (w_rend_go) r_rend_data <= w_rdata & w_mask;
            if (w_cpu_go && !w_req.wr) r_cpu_data <= 8'(w_rdata);
        end
    end

    assign busy        = r_busy;
    assign cpu_ack     = r_cpu_ack;
    assign cpu_data_o  = r_cpu_data;
    assign rend_valid  = r_rend_valid;
    assign rend_data_o = r_rend_data;

endmodule

// File: tb/tb_palette_ram_arb.sv
// Scoreboard bench for palette_ram_arb: mirrored instance 0, unmirrored instance 1.
module tb_palette_ram_arb;

    typedef struct {
        logic       is_rd;
        logic [7:0] data;
        int         cyc;
    } cexp_t;

    typedef struct {
        logic [5:0] data;
        int         cyc;
    } rexp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_rd_t   [2];
    logic       cpu_wr_t   [2];
    logic [4:0] cpu_addr_t [2];
    logic [7:0] cpu_din_t  [2];
    logic       rend_en_t  [2];
    logic [4:0] rend_addr_t[2];
    logic       grey_t     [2];
    logic       busy_w     [2];
    logic       ack_w      [2];
    logic [7:0] cdo_w      [2];
    logic       rv_w       [2];
    logic [5:0] rdo_w      [2];

    cexp_t qc0[$], qc1[$];
    rexp_t qr0[$], qr1[$];
    int    cyc      = 0;
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    palette_ram_arb #(.MIRROR_BG(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .busy(busy_w[0]),
        .cpu_addr(cpu_addr_t[0]), .cpu_rd(cpu_rd_t[0]), .cpu_wr(cpu_wr_t[0]),
        .cpu_data_i(cpu_din_t[0]), .cpu_data_o(cdo_w[0]), .cpu_ack(ack_w[0]),
        .rend_en(rend_en_t[0]), .rend_addr(rend_addr_t[0]), .greyscale(grey_t[0]),
        .rend_data_o(rdo_w[0]), .rend_valid(rv_w[0])
    );

    palette_ram_arb #(.MIRROR_BG(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .busy(busy_w[1]),
        .cpu_addr(cpu_addr_t[1]), .cpu_rd(cpu_rd_t[1]), .cpu_wr(cpu_wr_t[1]),
        .cpu_data_i(cpu_din_t[1]), .cpu_data_o(cdo_w[1]), .cpu_ack(ack_w[1]),
        .rend_en(rend_en_t[1]), .rend_addr(rend_addr_t[1]), .greyscale(grey_t[1]),
        .rend_data_o(rdo_w[1]), .rend_valid(rv_w[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cpush(input int s, input logic is_rd, input logic [7:0] d, input int c);
        cexp_t e;
        e = '{is_rd, d, c};
        if (s == 0) qc0.push_back(e); else qc1.push_back(e);
    endtask

    task automatic rpush(input int s, input logic [5:0] d, input int c);
        rexp_t e;
        e = '{d, c};
        if (s == 0) qr0.push_back(e); else qr1.push_back(e);
    endtask

    // Pop and compare whenever a DUT presents an ack or a render result.
    task automatic mon(input int s);
        cexp_t ce;
        rexp_t re;
        int    n;
        if (ack_w[s] === 1'b1) begin
            n = (s == 0) ? qc0.size() : qc1.size();
            chk($sformatf("dut%0d_ack_expected", s), 32'(n > 0), 1);
            if (n > 0) begin
                if (s == 0) ce = qc0.pop_front(); else ce = qc1.pop_front();
                chk($sformatf("dut%0d_ack_cycle", s), cyc, ce.cyc);
                if (ce.is_rd) chk($sformatf("dut%0d_cpu_data", s), cdo_w[s], ce.data);
            end
        end
        if (rv_w[s] === 1'b1) begin
            n = (s == 0) ? qr0.size() : qr1.size();
            chk($sformatf("dut%0d_rend_expected", s), 32'(n > 0), 1);
            if (n > 0) begin
                if (s == 0) re = qr0.pop_front(); else re = qr1.pop_front();
                chk($sformatf("dut%0d_rend_cycle", s), cyc, re.cyc);
                chk($sformatf("dut%0d_rend_data", s), rdo_w[s], re.data);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) mon(s);
    end

    task automatic cpu_op(input int s, input logic w, input logic r, input logic [4:0] a,
                          input logic [7:0] d, input logic [7:0] e);
        cpu_wr_t[s] = w; cpu_rd_t[s] = r; cpu_addr_t[s] = a; cpu_din_t[s] = d;
        cpush(s, r & ~w, e, cyc + 2);
        @(negedge clk);
        cpu_wr_t[s] = 1'b0; cpu_rd_t[s] = 1'b0;
        @(negedge clk);
    endtask

    task automatic rend(input int s, input logic [4:0] a, input logic g, input logic [5:0] e);
        rend_en_t[s] = 1'b1; rend_addr_t[s] = a; grey_t[s] = g;
        rpush(s, e, cyc + 1);
        @(negedge clk);
        rend_en_t[s] = 1'b0; grey_t[s] = 1'b0;
    endtask

    // Count busy cycles from reset release; mode 1 holds rend_en, mode 2 queues a write.
    task automatic clear_count(input int mode);
        int n;
        int s;
        n = 0;
        s = cyc;
        if (mode == 1) begin rend_en_t[0] = 1'b1; rend_addr_t[0] = 5'h00; end
        while (busy_w[0] === 1'b1 && n < 100) begin
            if (mode == 2 && n == 3) begin
                cpu_wr_t[0] = 1'b1; cpu_addr_t[0] = 5'h03; cpu_din_t[0] = 8'h2A;
                cpush(0, 1'b0, 8'h00, s + 33);
            end
            if (mode == 2 && n == 4) cpu_wr_t[0] = 1'b0;
            n++;
            @(negedge clk);
        end
        rend_en_t[0] = 1'b0;
        chk($sformatf("busy_len_mode%0d", mode), n, 32);
    endtask

    initial begin
        int n;
        for (int s = 0; s < 2; s++) begin
            cpu_rd_t[s] = 1'b0; cpu_wr_t[s] = 1'b0; cpu_addr_t[s] = '0; cpu_din_t[s] = '0;
            rend_en_t[s] = 1'b0; rend_addr_t[s] = '0; grey_t[s] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("dut%0d_rst_busy", s), busy_w[s], 1);
            chk($sformatf("dut%0d_rst_ack", s), ack_w[s], 0);
            chk($sformatf("dut%0d_rst_rvalid", s), rv_w[s], 0);
            chk($sformatf("dut%0d_rst_cdata", s), cdo_w[s], 0);
            chk($sformatf("dut%0d_rst_rdata", s), rdo_w[s], 0);
        end
        rst = 1'b0;
        clear_count(1);
        chk("dut1_busy_done", busy_w[1], 0);

        for (int a = 0; a < 32; a++) cpu_op(0, 1'b0, 1'b1, 5'(a), 8'h00, 8'h00);

        cpu_op(0, 1'b1, 1'b0, 5'h10, 8'h21, 8'h00);
        rend(0, 5'h00, 1'b0, 6'h21);
        cpu_op(0, 1'b1, 1'b0, 5'h11, 8'h15, 8'h00);
        rend(0, 5'h01, 1'b0, 6'h00);
        rend(0, 5'h11, 1'b0, 6'h15);
        cpu_op(0, 1'b0, 1'b1, 5'h00, 8'h00, 8'h21);
        cpu_op(1, 1'b1, 1'b0, 5'h10, 8'h21, 8'h00);
        rend(1, 5'h00, 1'b0, 6'h00);
        rend(1, 5'h10, 1'b0, 6'h21);

        // Pending write starved by ten render cycles.
        cpu_wr_t[0] = 1'b1; cpu_addr_t[0] = 5'h05; cpu_din_t[0] = 8'h3F;
        cpush(0, 1'b0, 8'h00, cyc + 12);
        @(negedge clk);
        cpu_wr_t[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rend_en_t[0] = 1'b1; rend_addr_t[0] = 5'h00;
            rpush(0, 6'h21, cyc + 1);
            @(negedge clk);
        end
        rend_en_t[0] = 1'b0;
        repeat (2) @(negedge clk);
        rend(0, 5'h05, 1'b0, 6'h3F);
        cpu_op(0, 1'b0, 1'b1, 5'h05, 8'h00, 8'h3F);

        cpu_op(0, 1'b1, 1'b0, 5'h07, 8'hFF, 8'h00);
        cpu_op(0, 1'b0, 1'b1, 5'h07, 8'h00, 8'h3F);
        rend(0, 5'h07, 1'b1, 6'h30);
        rend(0, 5'h07, 1'b0, 6'h3F);
        rend(0, 5'h00, 1'b1, 6'h20);
        cpu_op(0, 1'b1, 1'b1, 5'h09, 8'h0A, 8'h00);
        cpu_op(0, 1'b0, 1'b1, 5'h09, 8'h00, 8'h0A);

        // Render and pending write to the same address in one cycle: render sees old data.
        cpu_wr_t[0] = 1'b1; cpu_addr_t[0] = 5'h0B; cpu_din_t[0] = 8'h1C;
        cpush(0, 1'b0, 8'h00, cyc + 3);
        @(negedge clk);
        cpu_wr_t[0] = 1'b0;
        rend_en_t[0] = 1'b1; rend_addr_t[0] = 5'h0B;
        rpush(0, 6'h00, cyc + 1);
        @(negedge clk);
        rend_en_t[0] = 1'b0;
        @(negedge clk);
        rend(0, 5'h0B, 1'b0, 6'h1C);

        // Second write while the slot is full is dropped.
        cpu_wr_t[0] = 1'b1; cpu_addr_t[0] = 5'h0A; cpu_din_t[0] = 8'h11;
        cpush(0, 1'b0, 8'h00, cyc + 2);
        @(negedge clk);
        cpu_din_t[0] = 8'h22;
        @(negedge clk);
        cpu_wr_t[0] = 1'b0;
        @(negedge clk);
        cpu_op(0, 1'b0, 1'b1, 5'h0A, 8'h00, 8'h11);

        // Reset at clr_cnt=12 with a write pending: no ack, full clear restarts.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (n < 12) begin
            if (n == 5) begin cpu_wr_t[0] = 1'b1; cpu_addr_t[0] = 5'h04; cpu_din_t[0] = 8'h3C; end
            if (n == 6) cpu_wr_t[0] = 1'b0;
            n++;
            @(negedge clk);
        end
        chk("busy_mid_clear", busy_w[0], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_count(2);
        repeat (2) @(negedge clk);
        cpu_op(0, 1'b0, 1'b1, 5'h03, 8'h00, 8'h2A);
        cpu_op(0, 1'b0, 1'b1, 5'h04, 8'h00, 8'h00);
        cpu_op(0, 1'b0, 1'b1, 5'h05, 8'h00, 8'h00);

        repeat (4) @(negedge clk);
        chk("dut0_cpu_q_empty", qc0.size(), 0);
        chk("dut1_cpu_q_empty", qc1.size(), 0);
        chk("dut0_rend_q_empty", qr0.size(), 0);
        chk("dut1_rend_q_empty", qr1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
